// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nn_pkg
//  Description : Shared defaults for the activation-fetch datapath (burst
//                length, data/address widths, BRAM read latency) and the
//                state encoding used by the act_reader control FSM.
//  Revision    : 1.0  initial release
// ============================================================================
package nn_pkg;

  localparam int c_N      = 28;  // activations per burst (one layer row)
  localparam int c_DW     = 8;   // activation width, signed two's complement
  localparam int c_AW     = 11;  // BRAM address width
  localparam int c_RD_LAT = 1;   // BRAM address-sampling edge to DO valid

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

endpackage : nn_pkg
`default_nettype wire

// File: rtl/act_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : act_reader_if
//  Description : Single-port BRAM read bus between the activation reader
//                (master) and the BRAM (slave).
//                  bram_addr : AW  read address (master -> BRAM)
//                  bram_en   : 1   read enable  (master -> BRAM)
//                  bram_we   : 1   write enable, always 0 from the reader
//                  bram_dout : DW  read data    (BRAM -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface act_reader_if #(
  parameter int AW = 11,
  parameter int DW = 8
);

  logic [AW-1:0] bram_addr;
  logic          bram_en;
  logic          bram_we;
  logic [DW-1:0] bram_dout;

  modport master (
    output bram_addr,
    output bram_en,
    output bram_we,
    input  bram_dout
  );

  modport slave (
    input  bram_addr,
    input  bram_en,
    input  bram_we,
    output bram_dout
  );

endinterface : act_reader_if
`default_nettype wire

// File: rtl/rd_lat_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : rd_lat_pipe
//  Description : DEPTH-stage valid + index delay line. Each issued BRAM read
//                enters with its burst index and leaves the tail exactly when
//                the matching read data is on the BRAM output.
//                  clk, rst_n          : clock, async active-low reset
//                  in_valid / in_idx   : read issued this cycle and its index
//                  out_valid / out_idx : read data for out_idx is on DO now
//  Revision    : 1.0  initial release
// ============================================================================
module rd_lat_pipe #(
  parameter int DEPTH = 1,
  parameter int IW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [IW-1:0] in_idx,
  output logic          out_valid,
  output logic [IW-1:0] out_idx
);

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0][IW-1:0] idx_q, idx_d;

  always_comb begin
    valid_d    = valid_q;
    idx_d      = idx_q;
    valid_d[0] = in_valid;
    idx_d[0]   = in_idx;
    for (int s = 1; s < DEPTH; s++) begin
      valid_d[s] = valid_q[s-1];
      idx_d[s]   = idx_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_idx   = idx_q[DEPTH-1];

endmodule : rd_lat_pipe
`default_nettype wire

// File: rtl/act_reader.sv
`default_nettype none
// ============================================================================
//  Module      : act_reader
//  Description : Fetches one row of N activations from a single-port BRAM as
//                a back-to-back read burst and assembles them into a flat
//                vector act_out[DW*i +: DW] = mem[base_addr+i] (mod 2^AW).
//                  clk, rst_n  : clock, async active-low reset
//                  start       : one-cycle fetch request (honoured in IDLE)
//                  base_addr   : first BRAM address, captured with start
//                  bram        : BRAM read bus (master side)
//                  act_out     : captured burst, N*DW bits
//                  busy        : burst in progress (ISSUE/DRAIN/DONE)
//                  done        : one-cycle pulse, act_out complete
//                  act_valid   : act_out holds a complete burst
//  Revision    : 1.0  initial release
// ============================================================================
module act_reader
  import nn_pkg::*;
#(
  parameter int N      = c_N,
  parameter int DW     = c_DW,
  parameter int AW     = c_AW,
  parameter int RD_LAT = c_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AW-1:0]     base_addr,
  act_reader_if.master      bram,
  output logic [N*DW-1:0]   act_out,
  output logic              busy,
  output logic              done,
  output logic              act_valid
);

  localparam int            IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  rd_state_e         state_q, state_d;
  logic [AW-1:0]     base_q, base_d;
  logic [AW-1:0]     bram_addr_q, bram_addr_d;
  logic              bram_en_q, bram_en_d;
  logic [IW-1:0]     issue_cnt_q, issue_cnt_d;
  logic [IW-1:0]     rd_idx_q, rd_idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              act_valid_q, act_valid_d;
  logic [N*DW-1:0]   act_out_q, act_out_d;

  logic              tail_valid;
  logic [IW-1:0]     tail_idx;

  // The index travels beside the registered address, so the pipe sees a read
  // in the same cycle the BRAM does and its tail lines up with DO.
  rd_lat_pipe #(
    .DEPTH (RD_LAT),
    .IW    (IW)
  ) u_rd_lat_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bram_en_q),
    .in_idx    (rd_idx_q),
    .out_valid (tail_valid),
    .out_idx   (tail_idx)
  );

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    bram_addr_d = bram_addr_q;
    bram_en_d   = 1'b0;
    issue_cnt_d = issue_cnt_q;
    rd_idx_d    = rd_idx_q;
    act_valid_d = act_valid_q;
    act_out_d   = act_out_q;

    // Capture runs independently of the FSM state: the last reads land while
    // the FSM is already in DRAIN.
    if (tail_valid) begin
      act_out_d[int'(tail_idx)*DW +: DW] = bram.bram_dout;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d      = base_addr;
          issue_cnt_d = '0;
          act_valid_d = 1'b0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Address sum truncates to AW bits, so a burst near the top of the
        // BRAM wraps to address 0.
        bram_addr_d = base_q + AW'(issue_cnt_q);
        bram_en_d   = 1'b1;
        rd_idx_d    = issue_cnt_q;
        issue_cnt_d = issue_cnt_q + 1'b1;
        if (issue_cnt_q == LAST_IDX) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (tail_valid && (tail_idx == LAST_IDX)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered from the next state so they change on the
    // same edge as the state they describe.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    if (state_d == ST_DONE) begin
      act_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      bram_addr_q <= '0;
      bram_en_q   <= 1'b0;
      issue_cnt_q <= '0;
      rd_idx_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      act_valid_q <= 1'b0;
      act_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      bram_addr_q <= bram_addr_d;
      bram_en_q   <= bram_en_d;
      issue_cnt_q <= issue_cnt_d;
      rd_idx_q    <= rd_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      act_valid_q <= act_valid_d;
      act_out_q   <= act_out_d;
    end
  end

  assign bram.bram_addr = bram_addr_q;
  assign bram.bram_en   = bram_en_q;
  assign bram.bram_we   = 1'b0;
  assign act_out        = act_out_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign act_valid      = act_valid_q;

endmodule : act_reader
`default_nettype wire
